// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern engine.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    ROT_UP   = 2'd0,
    ROT_DOWN = 2'd1,
    BOUNCE   = 2'd2,
    FILL     = 2'd3
  } mode_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    FILLING  = 1'b0,
    EMPTYING = 1'b1
  } phase_e;

  // Prescaler counter width; a divide-by-1 still needs one bit of storage.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 32'd1) ? $clog2(div) : 32'd1;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running 0..DIV-1 counter that flags the step edge while enabled.
module step_prescaler
  import led_pattern_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

  logic [CW-1:0] r_cnt;

  // Step edge: last count reached while running.
  assign tick = en && (r_cnt == LAST);

  // Count while enabled; wrap on the step edge, clear on pattern load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// Parametrised LED pattern generator: rotate, bounce and fill motions.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter int unsigned      DIV   = 50_000_000,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             step
);

  logic [WIDTH-1:0] r_leds;
  dir_e             r_dir;
  phase_e           r_phase;
  logic             r_step;

  logic [WIDTH-1:0] w_leds_nxt;
  logic [WIDTH-1:0] w_fill_pat;
  dir_e             w_dir_nxt;
  phase_e           w_phase_nxt;
  logic             w_step_nxt;
  logic             w_tick;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);

  step_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (w_tick)
  );

  // Next pattern/direction/phase: load beats step, step beats hold.
  always_comb begin
    w_leds_nxt  = r_leds;
    w_dir_nxt   = r_dir;
    w_phase_nxt = r_phase;
    w_step_nxt  = 1'b0;
    w_fill_pat  = {r_leds[WIDTH-2:0], (r_phase == FILLING)};

    if (load) begin
      w_leds_nxt  = load_val;
      w_dir_nxt   = UP;
      w_phase_nxt = FILLING;
    end else if (w_tick) begin
      w_step_nxt  = 1'b1;
      w_dir_nxt   = UP;
      w_phase_nxt = FILLING;
      unique case (w_mode)
        ROT_UP:   w_leds_nxt = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
        ROT_DOWN: w_leds_nxt = {r_leds[0], r_leds[WIDTH-1:1]};
        BOUNCE: begin
          w_dir_nxt = r_dir;
          if (r_leds == '0) begin
            // An empty pattern would never move again; reseed it.
            w_leds_nxt = INIT;
          end else if ((r_dir == UP) && r_leds[WIDTH-1]) begin
            w_dir_nxt  = DOWN;
            w_leds_nxt = r_leds >> 1;
          end else if ((r_dir == DOWN) && r_leds[0]) begin
            w_dir_nxt  = UP;
            w_leds_nxt = r_leds << 1;
          end else if (r_dir == UP) begin
            w_leds_nxt = r_leds << 1;
          end else begin
            w_leds_nxt = r_leds >> 1;
          end
        end
        FILL: begin
          w_leds_nxt  = w_fill_pat;
          w_phase_nxt = r_phase;
          if ((r_phase == FILLING) && (&w_fill_pat)) begin
            w_phase_nxt = EMPTYING;
          end else if ((r_phase == EMPTYING) && (w_fill_pat == '0)) begin
            w_phase_nxt = FILLING;
          end
        end
        default: w_leds_nxt = r_leds;
      endcase
    end
  end

  // Pattern, motion state and step strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_leds  <= INIT;
      r_dir   <= UP;
      r_phase <= FILLING;
      r_step  <= 1'b0;
    end else begin
      r_leds  <= w_leds_nxt;
      r_dir   <= w_dir_nxt;
      r_phase <= w_phase_nxt;
      r_step  <= w_step_nxt;
    end
  end

  assign leds = r_leds;
  assign step = r_step;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (WIDTH=4, DIV=4, INIT=0001).
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] leds;
  logic       step;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur;

  led_pattern_engine #(
    .WIDTH (4),
    .DIV   (4),
    .INIT  (4'b0001)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .leds     (leds),
    .step     (step)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired bad=%0d", bad);
    $fatal(1, "timeout");
  end

  // Stimulus only: one-cycle load with a mode change, returns at the negedge after the load edge.
  task automatic do_load(input logic [3:0] v, input logic [1:0] m);
    @(negedge clk);
    load = 1'b1; load_val = v; mode = m;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; mode = 2'd0; load = 1'b0; load_val = 4'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (leds !== 4'b0001 || step !== 1'b0) begin
      bad++;
      $display("FAIL reset_state leds=%b step=%b want leds=0001 step=0", leds, step);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cur = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk); @(negedge clk);
        if (e == 4) begin
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          total++;
          if (leds !== cur || step !== 1'b1) begin
            bad++;
            $display("FAIL rot_up_step%0d leds=%b step=%b want leds=%b step=1", s, leds, step, cur);
          end
        end else begin
          total++;
          if (leds !== cur || step !== 1'b0) begin
            bad++;
            $display("FAIL rot_up_hold%0d_%0d leds=%b step=%b want leds=%b step=0", s, e, leds, step, cur);
          end
        end
      end
    end
  endtask

  task automatic test_rot_down();
    do_load(4'b0011, 2'd1);
    cur = 4'b0011;
    total++;
    if (leds !== cur || step !== 1'b0) begin
      bad++;
      $display("FAIL rot_down_load leds=%b step=%b want leds=%b step=0", leds, step, cur);
    end
    exp_q = '{4'b1001, 4'b1100, 4'b0110};
    for (int s = 0; s < 3; s++) begin
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk); @(negedge clk);
        if (e == 4) begin
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          total++;
          if (leds !== cur || step !== 1'b1) begin
            bad++;
            $display("FAIL rot_down_step%0d leds=%b step=%b want leds=%b step=1", s, leds, step, cur);
          end
        end else begin
          total++;
          if (leds !== cur || step !== 1'b0) begin
            bad++;
            $display("FAIL rot_down_hold%0d_%0d leds=%b step=%b want leds=%b step=0", s, e, leds, step, cur);
          end
        end
      end
    end
  endtask

  task automatic test_bounce();
    do_load(4'b0001, 2'd2);
    cur = 4'b0001;
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    for (int s = 0; s < 8; s++) begin
      if (s == 7) begin
        // Empty pattern must reseed from INIT on the next step.
        do_load(4'b0000, 2'd2);
        cur = 4'b0000;
        exp_q.push_back(4'b0001);
      end
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk); @(negedge clk);
        if (e == 4) begin
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          total++;
          if (leds !== cur || step !== 1'b1) begin
            bad++;
            $display("FAIL bounce_step%0d leds=%b step=%b want leds=%b step=1", s, leds, step, cur);
          end
        end else if (e == 2) begin
          total++;
          if (leds !== cur || step !== 1'b0) begin
            bad++;
            $display("FAIL bounce_hold%0d leds=%b step=%b want leds=%b step=0", s, leds, step, cur);
          end
        end
      end
    end
  endtask

  task automatic test_fill();
    do_load(4'b0000, 2'd3);
    cur = 4'b0000;
    exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
              4'b1100, 4'b1000, 4'b0000, 4'b0001};
    for (int s = 0; s < 9; s++) begin
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk); @(negedge clk);
        if (e == 4) begin
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          total++;
          if (leds !== cur || step !== 1'b1) begin
            bad++;
            $display("FAIL fill_step%0d leds=%b step=%b want leds=%b step=1", s, leds, step, cur);
          end
        end else if (e == 3) begin
          total++;
          if (leds !== cur || step !== 1'b0) begin
            bad++;
            $display("FAIL fill_hold%0d leds=%b step=%b want leds=%b step=0", s, leds, step, cur);
          end
        end
      end
    end
  endtask

  task automatic test_pause_collision();
    do_load(4'b0001, 2'd0);
    cur = 4'b0001;
    exp_q = '{4'b0010, 4'b1010};
    // 2 running edges, 3 paused, then the step lands on the 2nd running edge after.
    for (int e = 1; e <= 7; e++) begin
      en = (e >= 3 && e <= 5) ? 1'b0 : 1'b1;
      @(posedge clk); @(negedge clk);
      if (e == 7) begin
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        total++;
        if (leds !== cur || step !== 1'b1) begin
          bad++;
          $display("FAIL pause_step leds=%b step=%b want leds=%b step=1", leds, step, cur);
        end
      end else begin
        total++;
        if (leds !== cur || step !== 1'b0) begin
          bad++;
          $display("FAIL pause_hold%0d leds=%b step=%b want leds=%b step=0", e, leds, step, cur);
        end
      end
    end
    en = 1'b1;
    // Load lands on the would-be step edge (4th after the last step).
    for (int e = 1; e <= 8; e++) begin
      if (e == 4) begin load = 1'b1; load_val = 4'b0101; end
      else load = 1'b0;
      @(posedge clk); @(negedge clk);
      if (e == 4) cur = 4'b0101;
      if (e == 8) begin
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        total++;
        if (leds !== cur || step !== 1'b1) begin
          bad++;
          $display("FAIL collision_next_step leds=%b step=%b want leds=%b step=1", leds, step, cur);
        end
      end else begin
        total++;
        if (leds !== cur || step !== 1'b0) begin
          bad++;
          $display("FAIL collision_hold%0d leds=%b step=%b want leds=%b step=0", e, leds, step, cur);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_bounce();
    do_load(4'b0001, 2'd2);
    cur = 4'b0001;
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0100};
    for (int s = 0; s < 4; s++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      total++;
      if (leds !== cur || step !== 1'b1) begin
        bad++;
        $display("FAIL rst_bounce_step%0d leds=%b step=%b want leds=%b step=1", s, leds, step, cur);
      end
    end
    // dir is DOWN and step is high; reset must clear both without a clock edge.
    #1 rst = 1'b0;
    #1;
    total++;
    if (leds !== 4'b0001 || step !== 1'b0) begin
      bad++;
      $display("FAIL async_reset leds=%b step=%b want leds=0001 step=0", leds, step);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cur = 4'b0001;
    exp_q.push_back(4'b0010);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 4) begin
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        total++;
        if (leds !== cur || step !== 1'b1) begin
          bad++;
          $display("FAIL post_reset_step leds=%b step=%b want leds=%b step=1", leds, step, cur);
        end
      end else begin
        total++;
        if (leds !== cur || step !== 1'b0) begin
          bad++;
          $display("FAIL post_reset_hold%0d leds=%b step=%b want leds=%b step=0", e, leds, step, cur);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rot_down();
    test_bounce();
    test_fill();
    test_pause_collision();
    test_reset_mid_bounce();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover size=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator for the board-level status and demo outputs. It generalises the fixed 4-LED, 50 M-cycle rotating shift register to any LED count and any step period. It adds four motion modes, run/pause control, synchronous pattern load and a step strobe for downstream logic. It sits directly between the board clock/reset and the LED pins.

## Interface
- `WIDTH`, default 4: number of LEDs; legal range 2..32.
- `DIV`, default 50_000_000: clock cycles per pattern step; legal range 1..2^31-1.
- `INIT`, default 1 (WIDTH bits): pattern loaded at reset and on BOUNCE-empty recovery.
- `clk` in, 1: single clock; every register is clocked on the rising edge.
- `rst` in, 1: reset, asynchronous, active-low.
- `en` in, 1: 1 = run; 0 = pause, which freezes the prescaler, pattern, direction and phase.
- `mode` in, 2: 0 ROT_UP, 1 ROT_DOWN, 2 BOUNCE, 3 FILL; sampled only on step edges.
- `load` in, 1: synchronous pattern load; takes effect when high on a rising edge.
- `load_val` in, WIDTH: pattern written by `load`.
- `leds` out, WIDTH: current pattern; bit 0 is the first LED.
- `step` out, 1: one-cycle pulse, high during the cycle after each pattern update.

## Operation
- Prescaler `cnt` counts 0..DIV-1 while `en`=1. A step edge is the rising edge on which `cnt`==DIV-1 and `en`=1. On a step edge `cnt` wraps to 0. With DIV=1, every enabled edge is a step edge.
- Precedence on each edge: `load` first, then step, then hold.
- On `load`:
  - `leds`<=`load_val`, `cnt`<=0, `dir`<=UP, `phase`<=FILLING, `step`<=0.
  - `load` is honoured regardless of `en`.
- On a step edge, `leds` updates by mode:
  - ROT_UP: leds[i]<=leds[i-1]; leds[0]<=leds[WIDTH-1].
  - ROT_DOWN: leds[i]<=leds[i+1]; leds[WIDTH-1]<=leds[0].
  - BOUNCE: non-circular shift, zero fill.
    - If `dir`=UP and leds[WIDTH-1]=1: `dir`<=DOWN and the pattern shifts down.
    - Else if `dir`=DOWN and leds[0]=1: `dir`<=UP and the pattern shifts up.
    - Otherwise the pattern shifts in `dir`.
    - If `leds`==0 on the step edge, load INIT instead.
  - FILL: shift up.
    - `phase`=FILLING shifts a 1 into bit 0. `phase`=EMPTYING shifts a 0 into bit 0.
    - `phase` toggles on the step edge where the new pattern is all-ones (FILLING) or all-zeros (EMPTYING).
- `dir` is forced to UP on any step edge whose mode is not BOUNCE.
- `phase` is forced to FILLING on any step edge whose mode is not FILL.
- `step`<=1 on a step edge without `load`, otherwise 0.
- Changing `mode` between step edges has no visible effect until the next step edge.

## Timing
- Reset values: `leds`=INIT, `cnt`=0, `dir`=UP, `phase`=FILLING, `step`=0.
- First update: with `en`=1 held from reset release, `leds` first changes on the DIV-th rising edge after release. It then changes every DIV edges. `step` is high for exactly one cycle after each change.
- Pause: `en` low for k cycles delays the next step by exactly k cycles, and `cnt` resumes from its held value.
- Reset asserted mid-count or mid-BOUNCE/FILL restores every reset value immediately. No pending step survives reset.
- `load` on a would-be step edge: the load wins, `step`=0, and the next step comes DIV edges later.
- Prescaler counter width is max(1, $clog2(DIV)). No intermediate value may overflow.

## Structure
- Package `led_pattern_pkg` holds:
  - `mode_e` enum (ROT_UP, ROT_DOWN, BOUNCE, FILL);
  - `dir_e` (UP, DOWN);
  - `phase_e` (FILLING, EMPTYING).
- Sub-module `step_prescaler`:
  - params: DIV;
  - ports: clk, rst, en, clr;
  - output: `tick`, which is high combinationally when `cnt`==DIV-1 and `en`=1.
- The top level instantiates `step_prescaler` once and holds the pattern register, `dir`, `phase` and `step`.

## Test plan
All scenarios use WIDTH=4, DIV=4, INIT=4'b0001, `en`=1 unless stated.
- Reset and ROT_UP: release `rst`, mode 0. `leds` goes 0001→0010→0100→1000→0001, changing on edges 4, 8, 12, 16. `step` pulses one cycle after each change.
- ROT_DOWN with load: load 4'b0011, then mode 1. `leds` goes 0011→1001→1100→0110.
- BOUNCE: from 0001, mode 2. `leds` goes 0010, 0100, 1000, 0100, 0010, 0001, 0010. Load 0000, and the next step gives 0001.
- FILL: from 0000, mode 3. `leds` goes 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
- Pause and collision: `en` low for 3 cycles mid-count delays the step by exactly 3 edges. `load`=0101 on a step edge gives `leds`=0101 and `step`=0, with the next step 4 edges later.
- Async reset mid-BOUNCE while `dir`=DOWN: `leds`=0001, `step`=0 and `cnt`=0 without waiting for a clock edge. After release, the first step gives 0010.
